branch_target_predictor: RTL

Fetch-side dynamic branch predictor and the counterpart of the MEM-stage branch resolver. It is looked up combinationally with the fetch PC and returns a taken/not-taken prediction plus next-PC. It learns from resolved BEQ/BNE outcomes that the MEM stage sends back one per cycle. Storage is a direct-mapped branch target buffer whose entries each hold a 2-bit saturating counter. The block also keeps a saturating mispredict count for performance debug.

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/sat_counter2.sv | 21 ++
 rtl/branch_target_predictor.sv | 90 +++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: branch predictor counter encoding and BTB entry layout.
package cpu_types_pkg;

    localparam int BTB_ENTRIES = 8;
    // Sized for the smallest legal BTB (2 entries); larger BTBs leave upper tag bits at zero.
    localparam int BTB_TAG_W   = 29;
    localparam int BTB_TGT_W   = 30;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bpctr_t;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_TGT_W-1:0] target;
        bpctr_t               ctr;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import cpu_types_pkg::*;
(
    input  bpctr_t ctr_i,
    input  logic   taken_i,
    output bpctr_t ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        case (ctr_i)
            SNT: ctr_o = taken_i ? WNT : SNT;
            WNT: ctr_o = taken_i ? WT  : SNT;
            WT:  ctr_o = taken_i ? ST  : WNT;
            ST:  ctr_o = taken_i ? ST  : WT;
            default: ctr_o = ctr_i;
        endcase
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Fetch-side direct-mapped BTB with 2-bit counters, trained by resolved BEQ/BNE
// outcomes from MEM, plus a saturating mispredict counter.
module branch_target_predictor
    import cpu_types_pkg::*;
#(
    parameter  int ENTRIES = BTB_ENTRIES,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] fetch_pc,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_predicted,
    output logic [15:0] mispredict_cnt
);

    function automatic logic [BTB_TAG_W-1:0] tag_of(input logic [31:0] pc);
        return BTB_TAG_W'(pc >> (IDX_W + 2));
    endfunction

    btb_entry_t       btb_q [ENTRIES];
    btb_entry_t       btb_d [ENTRIES];
    logic [15:0]      mispredict_cnt_q, mispredict_cnt_d;

    logic [IDX_W-1:0] fetch_idx, upd_idx;
    btb_entry_t       fetch_e, upd_e;
    logic             fetch_hit, upd_hit;
    bpctr_t           upd_ctr_next;

    // Word-offset bits carry no information for a word-aligned PC or target.
    logic             unused_low_bits;
    assign unused_low_bits = ^{upd_pc[1:0], upd_target[1:0]};

    // Lookup reads the registered table only, so an update is never bypassed.
    assign fetch_idx      = fetch_pc[IDX_W+1:2];
    assign fetch_e        = btb_q[fetch_idx];
    assign fetch_hit      = fetch_e.valid && (fetch_e.tag == tag_of(fetch_pc));
    assign predict_taken  = fetch_hit && fetch_e.ctr[1];
    assign predict_target = predict_taken ? {fetch_e.target, 2'b00} : fetch_pc + 32'd4;
    assign mispredict_cnt = mispredict_cnt_q;

    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_e   = btb_q[upd_idx];
    assign upd_hit = upd_e.valid && (upd_e.tag == tag_of(upd_pc));

    sat_counter2 u_sat_counter2 (
        .ctr_i   (upd_e.ctr),
        .taken_i (upd_taken),
        .ctr_o   (upd_ctr_next)
    );

    always_comb begin
        // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
        btb_d            = btb_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (upd_en) begin
            if (upd_hit) begin
                btb_d[upd_idx].ctr = upd_ctr_next;
                if (upd_taken) begin
                    btb_d[upd_idx].target = upd_target[31:2];
                end
            end else if (upd_taken) begin
                btb_d[upd_idx] = '{valid: 1'b1, tag: tag_of(upd_pc),
                                   target: upd_target[31:2], ctr: WT};
            end
            if ((upd_predicted != upd_taken) && (mispredict_cnt_q != 16'hFFFF)) begin
                mispredict_cnt_d = mispredict_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: the table is a flop array, not SRAM, so reset clears every entry asynchronously.
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
            mispredict_cnt_q <= '0;
        end else begin
            btb_q            <= btb_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

endmodule
